inst_axi_responder: RTL and testbench
=====================================

Name: inst_axi_responder

Overview:
- Responder end of the instruction-fetch SRAM-like protocol.
- Accepts fetch requests (inst_req/inst_addr) from the first fetch stage and returns one aligned group of LINE_WORDS instruction words per request, via a single-cycle inst_data_ok pulse to the second fetch stage.
- Converts each request into one AXI4 INCR read burst on the instruction port of the bus.

Parameters:
- LINE_WORDS, 4: words per fetch group; power of two, 2..16; arlen = LINE_WORDS-1.
- AR_ID, 4'd0: constant arid for every burst.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- inst_req  in  1  fetch request valid
- inst_addr  in  32  fetch address (physical); low log2(LINE_WORDS*4) bits ignored
- inst_addr_ok  out  1  request accepted this cycle when inst_req=1
- inst_data_ok  out  1  one-cycle pulse: inst_rdata/inst_err valid
- inst_rdata  out  32*LINE_WORDS  fetched words; word i = burst beat i at bits [32i+31:32i]
- inst_err  out  1  bus error on any beat of this burst; qualified by inst_data_ok
- arid  out  4  =AR_ID
- araddr  out  32  {addr[31:log2(LINE_WORDS*4)], zeros}
- arlen  out  8  LINE_WORDS-1
- arsize  out  3  3'b010
- arburst  out  2  2'b01 (INCR)
- arvalid  out  1  address valid
- arready  in  1  address ready
- rdata  in  32  read data
- rresp  in  2  read response
- rlast  in  1  last beat
- rvalid  in  1  read valid
- rready  out  1  read ready

Behaviour:
- States: IDLE, AR, R, DONE. Reset -> IDLE.
- Reset values: arvalid=0, rready=0, inst_data_ok=0, inst_err=0, inst_rdata=0, araddr=0, beat counter=0.
- inst_addr_ok is combinational: 1 in IDLE or DONE, else 0. A request is accepted when inst_req && inst_addr_ok. At most one outstanding request.
- IDLE:
  - on accept: latch aligned address, clear beat counter and error flag -> AR.
- AR:
  - arvalid=1; araddr stable until handshake.
  - on arvalid&&arready -> R.
  - arvalid never drops before handshake.
- R:
  - rready=1.
  - each rvalid beat writes rdata to word[counter]; counter++; err |= (rresp!=0).
  - on rlast beat -> DONE.
  - rlast before counter reaches LINE_WORDS-1: remaining words keep prior contents, err set, -> DONE.
  - a beat past LINE_WORDS-1 without rlast is not stored; err set; stay in R until rlast.
- DONE:
  - inst_data_ok=1 for exactly this cycle; inst_rdata/inst_err driven from the line buffer.
  - if a new request is accepted in the same cycle -> AR with the new address, back-to-back; else -> IDLE.
  - inst_rdata holds its value after DONE until the next burst's first beat.
- Cancellation is the requester's concern: every accepted request produces exactly one inst_data_ok, in order. No cancel input exists.
- Minimum latency with arready=1 and back-to-back rvalid: accept at T0, arvalid T1, beats T2..T(1+LINE_WORDS), inst_data_ok at T(2+LINE_WORDS), i.e. T6 for LINE_WORDS=4.
- rst asserted mid-burst: FSM returns to IDLE next edge and the in-flight burst is abandoned. A system-wide reset of the AXI interconnect is required.
- araddr alignment: address bits [log2(LINE_WORDS*4)-1:0] forced to 0.

Test Plan:
- Single fetch: inst_req=1, addr=0xBFC0_0004, arready=1, beats 0x11,0x22,0x33,0x44 with rlast on the 4th -> araddr=0xBFC0_0000, arlen=3, arsize=2, arburst=1; inst_data_ok pulses at T6; inst_rdata=0x00000044_00000033_00000022_00000011; inst_err=0.
- Back-to-back: second request held high with addr 0xBFC0_0010 -> accepted in the DONE cycle; arvalid next cycle with araddr=0xBFC0_0010; no IDLE bubble.
- Backpressure: arready low for 5 cycles, then 1 gap cycle between each rvalid beat -> arvalid and araddr stable throughout; inst_addr_ok=0 until DONE; exactly one inst_data_ok.
- Error: rresp=2'b10 on beat 2 only -> inst_err=1 with inst_data_ok; the next clean burst returns inst_err=0.
- Early rlast on beat 2 (LINE_WORDS=4) -> inst_data_ok after beat 2, inst_err=1, FSM returns to IDLE.
- Reset mid-R (after 2 beats) -> next cycle state IDLE, inst_addr_ok=1, rready=0, inst_data_ok=0, inst_rdata=0.

Source files
------------

// File: rtl/inst_axi_responder.sv
// Instruction-fetch responder: turns each SRAM-like fetch request into one
// AXI4 INCR read burst and returns the whole line with a one-cycle pulse.
module inst_axi_responder #(
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [3:0]  AR_ID      = 4'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_req,
    input  logic [31:0]             inst_addr,
    output logic                    inst_addr_ok,
    output logic                    inst_data_ok,
    output logic [32*LINE_WORDS-1:0] inst_rdata,
    output logic                    inst_err,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int unsigned OFF = $clog2(LINE_WORDS * 4);
    localparam int unsigned CW  = $clog2(LINE_WORDS) + 1;
    localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
    localparam logic [CW-1:0] FULL = CW'(LINE_WORDS);

    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]                  cnt;
    logic                           err;
    logic [LINE_WORDS-1:0][31:0]    line;
    logic                           accept;
    logic                           beat;
    logic                           unused_addr;

    assign inst_addr_ok = (state == IDLE) || (state == DONE);
    assign accept       = inst_req && inst_addr_ok;
    assign beat         = (state == R) && rvalid;

    assign arvalid      = (state == AR);
    assign rready       = (state == R);
    assign inst_data_ok = (state == DONE);
    assign inst_err     = inst_data_ok && err;
    assign inst_rdata   = line;

    assign arid    = AR_ID;
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    assign unused_addr = ^inst_addr[OFF-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = AR;
            AR:   if (arready) state_nxt = R;
            R:    if (rvalid && rlast) state_nxt = DONE;
            DONE: state_nxt = accept ? AR : IDLE;
        endcase
    end

    // Counter saturates at FULL so overrun beats are dropped but still flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            araddr <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            line   <= '0;
        end else begin
            if (accept) begin
                araddr <= {inst_addr[31:OFF], {OFF{1'b0}}};
                cnt    <= '0;
                err    <= 1'b0;
            end
            if (beat) begin
                if (cnt < FULL) begin
                    line[cnt[CW-2:0]] <= rdata;
                    cnt               <= cnt + 1'b1;
                end
                if ((rresp != 2'b00) || (cnt >= FULL) ||
                    (rlast && (cnt != LAST))) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_axi_responder.sv
// Directed bench for inst_axi_responder: AXI slave driver, line model and
// a per-cycle checker of fetch responses and AR channel behaviour.
module tb_inst_axi_responder;

    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_req;
    logic [31:0]       inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [32*LW-1:0]  inst_rdata;
    logic              inst_err;
    logic [3:0]        arid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    inst_axi_responder #(.LINE_WORDS(LW), .AR_ID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .inst_err(inst_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timeout", name);
    endtask

    typedef struct packed {
        logic [7:0][31:0] d;
        logic [7:0][1:0]  r;
        int               ard;
        int               gap;
        int               n;
        logic             last;
    } desc_t;

    typedef struct packed {
        logic [32*LW-1:0] data;
        logic             err;
    } exp_t;

    desc_t       desc_q[$];
    exp_t        exp_q[$];
    logic [31:0] ar_q[$];
    int          acc_q[$];

    logic [32*LW-1:0] mline = '0;

    int               outst = 0;
    int               dok_cnt = 0;
    int               last_lat = 0;
    logic [32*LW-1:0] last_data = '0;
    logic             last_err = 1'b0;
    logic [31:0]      last_ar = '0;
    logic             ar_hold = 1'b0;
    logic [31:0]      ar_prev = '0;

    // Checker: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            outst = 0;
            ar_hold = 1'b0;
            ar_q.delete();
            acc_q.delete();
        end else begin
            check("addr_ok", inst_addr_ok, (outst == 0) || inst_data_ok);
            if (inst_data_ok) begin
                dok_cnt++;
                last_data = inst_rdata;
                last_err = inst_err;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_data_ok: got 1 expected 0");
                end else begin
                    e = exp_q.pop_front();
                    check("inst_rdata", inst_rdata, e.data);
                    check("inst_err", inst_err, e.err);
                end
                if (acc_q.size() > 0) last_lat = cyc - acc_q.pop_front();
                outst--;
            end
            if (inst_req && inst_addr_ok) begin
                outst++;
                acc_q.push_back(cyc);
            end
            if (ar_hold) begin
                check("arvalid_hold", arvalid, 1'b1);
                check("araddr_hold", araddr, ar_prev);
            end
            if (arvalid) begin
                check("arid", arid, 4'd0);
                check("arlen", arlen, 8'(LW - 1));
                check("arsize", arsize, 3'b010);
                check("arburst", arburst, 2'b01);
            end
            if (arvalid && arready) begin
                last_ar = araddr;
                if (ar_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_ar: got %0h expected none", araddr);
                end else begin
                    check("araddr", araddr, ar_q.pop_front());
                end
            end
            ar_hold = arvalid && !arready;
            ar_prev = araddr;
        end
    end

    // AXI read slave replaying queued burst descriptors.
    initial begin
        desc_t d;
        int k;
        arready = 1'b0;
        rvalid = 1'b0;
        rdata = '0;
        rresp = '0;
        rlast = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (desc_q.size() == 0 || rst) continue;
            d = desc_q[0];
            k = 0;
            while (!arvalid && k < 200) begin
                @(posedge clk);
                #1;
                k++;
            end
            if (!arvalid) begin
                fail_now("arvalid_wait");
                void'(desc_q.pop_front());
                continue;
            end
            repeat (d.ard) begin
                @(posedge clk);
                #1;
            end
            arready = 1'b1;
            @(posedge clk);
            #1;
            arready = 1'b0;
            for (int i = 0; i < d.n; i++) begin
                if (i > 0) begin
                    repeat (d.gap) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rvalid = 1'b1;
                rdata = d.d[i];
                rresp = d.r[i];
                rlast = d.last && (i == d.n - 1);
                k = 0;
                while (!rready && k < 50) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                if (!rready) fail_now("rready_wait");
                @(posedge clk);
                #1;
                rvalid = 1'b0;
                rlast = 1'b0;
            end
            void'(desc_q.pop_front());
        end
    end

    function automatic desc_t mk(input int ard, input int gap, input int n,
                                 input logic last, input logic [31:0] base,
                                 input int eb);
        desc_t d;
        d = '0;
        d.ard = ard;
        d.gap = gap;
        d.n = n;
        d.last = last;
        for (int i = 0; i < 8; i++) begin
            d.d[i] = base * 32'(i + 1);
            d.r[i] = (i == eb) ? 2'b10 : 2'b00;
        end
        return d;
    endfunction

    // Line model: beats land at their index, anything but an exact clean
    // LW-beat burst ending in rlast is an error.
    task automatic issue(input logic [31:0] a, input desc_t d, input bit abandon);
        exp_t e;
        logic er;
        er = 1'b0;
        for (int i = 0; i < d.n; i++) begin
            if (i < LW) mline[i*32 +: 32] = d.d[i];
            if (d.r[i] != 2'b00) er = 1'b1;
        end
        if (d.n != LW || !d.last) er = 1'b1;
        e.data = mline;
        e.err = er;
        if (!abandon) exp_q.push_back(e);
        ar_q.push_back(a & ~32'(LW * 4 - 1));
        desc_q.push_back(d);
    endtask

    task automatic request(input logic [31:0] a, output logic dok);
        int k;
        k = 0;
        inst_req = 1'b1;
        inst_addr = a;
        while (!inst_addr_ok && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!inst_addr_ok) fail_now("accept_wait");
        dok = inst_data_ok;
        @(posedge clk);
        #1;
        inst_req = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || desc_q.size() != 0) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 300) fail_now("wait_idle");
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic dok;
        int d0;
        int k;
        rst = 1'b1;
        inst_req = 1'b0;
        inst_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_data_ok", inst_data_ok, 1'b0);
        check("rst_err", inst_err, 1'b0);
        check("rst_rdata", inst_rdata, '0);
        check("rst_araddr", araddr, 32'h0);
        check("rst_addr_ok", inst_addr_ok, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(32'hBFC0_0004, mk(0, 0, 4, 1'b1, 32'h11, -1), 1'b0);
        request(32'hBFC0_0004, dok);
        wait_idle();
        check("single_latency", last_lat, 6);
        check("single_rdata", last_data,
              128'h00000044_00000033_00000022_00000011);
        check("single_err", last_err, 1'b0);
        check("single_araddr", last_ar, 32'hBFC0_0000);

        issue(32'hBFC0_0100, mk(0, 0, 4, 1'b1, 32'h100, -1), 1'b0);
        issue(32'hBFC0_0010, mk(0, 0, 4, 1'b1, 32'h200, -1), 1'b0);
        request(32'hBFC0_0100, dok);
        request(32'hBFC0_0010, dok);
        check("b2b_accept_in_done", dok, 1'b1);
        check("b2b_arvalid", arvalid, 1'b1);
        check("b2b_araddr", araddr, 32'hBFC0_0010);
        wait_idle();

        d0 = dok_cnt;
        issue(32'h1000_0024, mk(5, 1, 4, 1'b1, 32'h5, -1), 1'b0);
        request(32'h1000_0024, dok);
        wait_idle();
        check("bp_one_data_ok", dok_cnt - d0, 1);

        issue(32'h2000_0000, mk(0, 0, 4, 1'b1, 32'h7, 1), 1'b0);
        request(32'h2000_0000, dok);
        wait_idle();
        check("resp_err", last_err, 1'b1);
        issue(32'h2000_0040, mk(0, 0, 4, 1'b1, 32'h9, -1), 1'b0);
        request(32'h2000_0040, dok);
        wait_idle();
        check("clean_after_err", last_err, 1'b0);

        issue(32'h2000_0080, mk(0, 0, 2, 1'b1, 32'hA, -1), 1'b0);
        request(32'h2000_0080, dok);
        wait_idle();
        check("early_err", last_err, 1'b1);
        check("early_rdata", last_data,
              128'h00000024_0000001b_00000014_0000000a);
        check("early_idle_addr_ok", inst_addr_ok, 1'b1);
        check("early_idle_rready", rready, 1'b0);

        issue(32'h2000_00C0, mk(0, 0, 5, 1'b1, 32'h3, -1), 1'b0);
        request(32'h2000_00C0, dok);
        wait_idle();
        check("overrun_err", last_err, 1'b1);

        issue(32'h3000_0000, mk(0, 0, 2, 1'b0, 32'h55, -1), 1'b1);
        request(32'h3000_0000, dok);
        k = 0;
        while (desc_q.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 100) fail_now("abandon_beats");
        d0 = dok_cnt;
        rst = 1'b1;
        mline = '0;
        @(posedge clk);
        #1;
        check("rst_mid_addr_ok", inst_addr_ok, 1'b1);
        check("rst_mid_rready", rready, 1'b0);
        check("rst_mid_data_ok", inst_data_ok, 1'b0);
        check("rst_mid_rdata", inst_rdata, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(32'h4000_0010, mk(0, 1, 4, 1'b1, 32'h21, 3), 1'b0);
        request(32'h4000_0010, dok);
        wait_idle();
        check("after_rst_count", dok_cnt - d0, 1);
        check("after_rst_rdata", last_data,
              128'h00000084_00000063_00000042_00000021);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
